// File: rtl/serial_rx_deframer.sv
// rtl/serial_rx_deframer.sv - asynchronous-serial receive deframer with mid-bit sampling
//
// Recovers LSB-first bytes from an already-synchronized serial line (idle high).
// Optional even-parity bit is compiled in when SERIAL_RX_PARITY_CHECK_EN is defined.
//
// Parameters:
//   CLKS_PER_BIT   clocks per serial bit (4..1023)
//   NUM_DATA_BITS  data bits per frame (5..8)
// Ports:
//   clk            system clock, rising edge
//   n_rst          asynchronous active-low reset
//   serial_in      synchronized serial line
//   data_read      consumer pulse acknowledging the current byte
//   rx_data        last good byte
//   data_ready     a good byte is waiting
//   framing_error  last frame had a low stop bit
//   overrun_error  a good byte overwrote an unread byte
//   parity_error   last frame failed even parity (constant 0 without the macro)

module serial_rx_deframer #(
    parameter int CLKS_PER_BIT  = 10,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     serial_in,
    input  logic                     data_read,
    output logic [NUM_DATA_BITS-1:0] rx_data,
    output logic                     data_ready,
    output logic                     framing_error,
    output logic                     overrun_error,
    output logic                     parity_error
);

    localparam logic [9:0] HALF_LAST = 10'(CLKS_PER_BIT / 2 - 1);
    localparam logic [9:0] FULL_LAST = 10'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT  = 3'(NUM_DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef SERIAL_RX_PARITY_CHECK_EN
        , PARITY
`endif
    } state_t;

    state_t                   state;
    logic                     prev;
    logic [9:0]               cnt;
    logic [2:0]               bit_idx;
    logic [NUM_DATA_BITS-1:0] shift_reg;

`ifdef SERIAL_RX_PARITY_CHECK_EN
    logic par_bad;
`else
    assign parity_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            prev          <= 1'b1;
            cnt           <= '0;
            bit_idx       <= '0;
            shift_reg     <= '0;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
            par_bad       <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            prev <= serial_in;

            // Consumer acknowledge; a good load later in this block overrides it.
            if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Only a true 1->0 transition starts a frame, so a line
                    // stuck low after a bad frame cannot retrigger.
                    if (!serial_in && prev) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= serial_in ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end

                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt       <= '0;
                        // Shift in at the MSB so the LSB-first byte ends aligned.
                        shift_reg <= {serial_in, shift_reg[NUM_DATA_BITS-1:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
`ifdef SERIAL_RX_PARITY_CHECK_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end

`ifdef SERIAL_RX_PARITY_CHECK_EN
                PARITY: begin
                    if (cnt == FULL_LAST) begin
                        cnt     <= '0;
                        par_bad <= (^shift_reg) ^ serial_in;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end
`endif

                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (!serial_in) begin
                            framing_error <= 1'b1;
`ifdef SERIAL_RX_PARITY_CHECK_EN
                        end else if (par_bad) begin
                            parity_error  <= 1'b1;
                            framing_error <= 1'b0;
`endif
                        end else begin
                            rx_data       <= shift_reg;
                            data_ready    <= 1'b1;
                            framing_error <= 1'b0;
`ifdef SERIAL_RX_PARITY_CHECK_EN
                            parity_error  <= 1'b0;
`endif
                            if (data_ready && !data_read) begin
                                overrun_error <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt + 10'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_rx_deframer.sv
// tb/tb_serial_rx_deframer.sv - self-checking bench for serial_rx_deframer

module tb_serial_rx_deframer;

    localparam int CPB = 10;
    localparam int NDB = 8;

    logic           clk;
    logic           n_rst;
    logic           serial_in;
    logic           data_read;
    logic [NDB-1:0] rx_data;
    logic           data_ready;
    logic           framing_error;
    logic           overrun_error;
    logic           parity_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] rx;
        logic       ready;
        logic       fe;
        logic       ov;
        logic       pe;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_rx;
    logic       m_ready, m_fe, m_ov, m_pe;

    serial_rx_deframer #(
        .CLKS_PER_BIT (CPB),
        .NUM_DATA_BITS(NDB)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .serial_in    (serial_in),
        .data_read    (data_read),
        .rx_data      (rx_data),
        .data_ready   (data_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error),
        .parity_error (parity_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_rx = 8'h00; m_ready = 1'b0; m_fe = 1'b0; m_ov = 1'b0; m_pe = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        if (rx_data !== m_rx) begin
            errors++; $display("FAIL %s rx_data got %h want %h", tag, rx_data, m_rx);
        end
        checks++;
        if (data_ready !== m_ready) begin
            errors++; $display("FAIL %s data_ready got %b want %b", tag, data_ready, m_ready);
        end
        checks++;
        if (framing_error !== m_fe) begin
            errors++; $display("FAIL %s framing_error got %b want %b", tag, framing_error, m_fe);
        end
        checks++;
        if (overrun_error !== m_ov) begin
            errors++; $display("FAIL %s overrun_error got %b want %b", tag, overrun_error, m_ov);
        end
        checks++;
        if (parity_error !== m_pe) begin
            errors++; $display("FAIL %s parity_error got %b want %b", tag, parity_error, m_pe);
        end
    endtask

    // Sends one frame starting right after a clock edge; the start edge E is the
    // first edge that sees the line low. Expected outcome is pushed on entry and
    // popped exactly at the stop-sample edge.
    task automatic tx_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                            input logic rd_on_load, input int hold_low, input string tag);
        exp_t       e;
        logic       pre_ready;
        logic [7:0] pre_rx;
        logic       good;
        pre_ready = m_ready;
        pre_rx    = m_rx;
        good      = stop_b && !par_flip;
        if (good) begin
            m_ov    = rd_on_load ? 1'b0 : (m_ready ? 1'b1 : m_ov);
            m_rx    = d;
            m_ready = 1'b1;
            m_fe    = 1'b0;
            m_pe    = 1'b0;
        end else begin
            if (rd_on_load) begin
                m_ready = 1'b0;
                m_ov    = 1'b0;
            end
            if (stop_b) begin
                m_pe = 1'b1;
                m_fe = 1'b0;
            end else begin
                m_fe = 1'b1;
            end
        end
        e.rx = m_rx; e.ready = m_ready; e.fe = m_fe; e.ov = m_ov; e.pe = m_pe;
        sb.push_back(e);

        serial_in = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < NDB; i++) begin
            serial_in = d[i];
            repeat (CPB) tick();
        end
`ifdef SERIAL_RX_PARITY_CHECK_EN
        serial_in = (^d) ^ par_flip;
        repeat (CPB) tick();
`endif
        serial_in = stop_b;
        repeat (CPB / 2) tick();
        checks++;
        if (data_ready !== pre_ready) begin
            errors++; $display("FAIL %s early data_ready got %b want %b", tag, data_ready, pre_ready);
        end
        checks++;
        if (rx_data !== pre_rx) begin
            errors++; $display("FAIL %s early rx_data got %h want %h", tag, rx_data, pre_rx);
        end
        data_read = rd_on_load;
        tick();
        data_read = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            errors++; $display("FAIL %s scoreboard empty got 0 want 1", tag);
        end else begin
            e = sb.pop_front();
            checks++;
            if (rx_data !== e.rx) begin
                errors++; $display("FAIL %s rx_data got %h want %h", tag, rx_data, e.rx);
            end
            checks++;
            if (data_ready !== e.ready) begin
                errors++; $display("FAIL %s data_ready got %b want %b", tag, data_ready, e.ready);
            end
            checks++;
            if (framing_error !== e.fe) begin
                errors++; $display("FAIL %s framing_error got %b want %b", tag, framing_error, e.fe);
            end
            checks++;
            if (overrun_error !== e.ov) begin
                errors++; $display("FAIL %s overrun_error got %b want %b", tag, overrun_error, e.ov);
            end
            checks++;
            if (parity_error !== e.pe) begin
                errors++; $display("FAIL %s parity_error got %b want %b", tag, parity_error, e.pe);
            end
        end
        repeat (CPB - CPB / 2 - 1) tick();
        repeat (hold_low) tick();
        serial_in = 1'b1;
    endtask

    task automatic read_byte(input string tag);
        data_read = 1'b1;
        tick();
        data_read = 1'b0;
        m_ready = 1'b0;
        m_ov    = 1'b0;
        check_outputs(tag);
    endtask

    task automatic test_reset();
        n_rst = 1'b0; serial_in = 1'b1; data_read = 1'b0;
        model_clear();
        repeat (2) tick();
        check_outputs("reset");
        n_rst = 1'b1;
        repeat (200) tick();
        check_outputs("idle200");
    endtask

    task automatic test_good_frame();
        tx_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, "good_a5");
        read_byte("read_a5");
    endtask

    task automatic test_framing();
        tx_frame(8'h3C, 1'b0, 1'b0, 1'b0, 30, "frame_3c");
        repeat (10) tick();
        check_outputs("stuck_low");
        tx_frame(8'h01, 1'b1, 1'b0, 1'b0, 0, "good_01");
        read_byte("read_01");
    endtask

    task automatic test_back_to_back();
        tx_frame(8'h11, 1'b1, 1'b0, 1'b0, 0, "b2b_11");
        tx_frame(8'h22, 1'b1, 1'b0, 1'b0, 0, "overrun_22");
        read_byte("read_22");
        tx_frame(8'h33, 1'b1, 1'b0, 1'b0, 0, "b2b_33");
        tx_frame(8'h44, 1'b1, 1'b0, 1'b1, 0, "simul_44");
        read_byte("read_44");
    endtask

    task automatic test_glitch();
        repeat (5) tick();
        serial_in = 1'b0;
        repeat (3) tick();
        serial_in = 1'b1;
        repeat (20) tick();
        check_outputs("glitch");
    endtask

    task automatic test_reset_mid_frame();
        serial_in = 1'b0;
        repeat (CPB) tick();
        serial_in = 1'b1;
        repeat (30) tick();
        #2;
        n_rst = 1'b0;
        #1;
        model_clear();
        check_outputs("async_reset");
        tick();
        n_rst = 1'b1;
        repeat (15) tick();
        check_outputs("post_reset");
        tx_frame(8'h7E, 1'b1, 1'b0, 1'b0, 0, "good_7e");
        read_byte("read_7e");
    endtask

`ifdef SERIAL_RX_PARITY_CHECK_EN
    task automatic test_parity();
        tx_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0, "par_ok_a5");
        read_byte("read_par_a5");
        tx_frame(8'h5A, 1'b1, 1'b1, 1'b0, 0, "par_bad_5a");
        tx_frame(8'hC3, 1'b1, 1'b0, 1'b0, 0, "par_clear_c3");
        read_byte("read_par_c3");
    endtask
`endif

    initial begin
        test_reset();
        test_good_frame();
        test_framing();
        test_back_to_back();
        test_glitch();
        test_reset_mid_frame();
`ifdef SERIAL_RX_PARITY_CHECK_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
